// File: rtl/msrv32_pc_reg_block.sv
// Program-counter register for the msrv32 fetch stage with stall hold, flush bubble,
// misalignment flag, previous-PC tracking and a readable PC history ring.
module msrv32_pc_reg_block #(
    parameter int unsigned XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic                          ms_riscv32_mp_clk_in,
    input  logic                          ms_riscv32_mp_rst_in,
    input  logic [XLEN-1:0]               pc_mux_in,
    input  logic                          stall_in,
    input  logic                          flush_in,
    output logic [XLEN-1:0]               pc_out,
    output logic [XLEN-1:0]               pc_prev_out,
    output logic                          valid_out,
    output logic                          misaligned_out,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx_in,
    output logic [XLEN-1:0]               hist_data_out,
    output logic [$clog2(HIST_DEPTH):0]   hist_count_out
);

    localparam int unsigned IDX_W = $clog2(HIST_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [XLEN-1:0]  hist_mem [HIST_DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic             advance;
    logic             push;
    logic             mis_next;

    assign advance  = !flush_in && !stall_in;
    assign push     = advance && valid_out;
    assign mis_next = |pc_mux_in[ALIGN_BITS-1:0];

    // PC, previous PC, valid and misalignment flag
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            pc_out         <= RESET_VEC;
            pc_prev_out    <= RESET_VEC;
            valid_out      <= 1'b0;
            misaligned_out <= 1'b0;
        end else if (flush_in) begin
            pc_out         <= pc_mux_in;
            valid_out      <= 1'b0;
            misaligned_out <= mis_next;
        end else if (!stall_in) begin
            pc_out         <= pc_mux_in;
            pc_prev_out    <= pc_out;
            valid_out      <= 1'b1;
            misaligned_out <= mis_next;
        end
    end

    // History ring: only real fetches leaving pc_out are recorded
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wr_ptr         <= '0;
            hist_count_out <= '0;
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist_mem[i] <= '0;
            end
        end else if (push) begin
            hist_mem[wr_ptr] <= pc_out;
            wr_ptr           <= wr_ptr + IDX_W'(1);
            if (hist_count_out != CNT_W'(HIST_DEPTH)) begin
                hist_count_out <= hist_count_out + CNT_W'(1);
            end
        end
    end

    // Index 0 is the newest entry, i.e. the slot just behind the write pointer
    assign rd_ptr = wr_ptr - IDX_W'(1) - hist_rd_idx_in;

    always_comb begin
        hist_data_out = '0;
        if (CNT_W'(hist_rd_idx_in) < hist_count_out) begin
            hist_data_out = hist_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_msrv32_pc_reg_block.sv
// Directed self-checking bench for msrv32_pc_reg_block: vector table plus wrap/reset sequence.
module tb_msrv32_pc_reg_block;

    localparam int unsigned XLEN = 32;
    localparam int unsigned HD   = 4;
    localparam int unsigned IW   = $clog2(HD);

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] pc_mux;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_prev;
    logic            valid;
    logic            mis;
    logic [IW-1:0]   rd_idx;
    logic [XLEN-1:0] hist_data;
    logic [IW:0]     hist_count;

    int checks = 0;
    int errors = 0;

    msrv32_pc_reg_block #(
        .XLEN(XLEN), .RESET_VEC(32'h0), .ALIGN_BITS(2), .HIST_DEPTH(HD)
    ) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst_n),
        .pc_mux_in(pc_mux),
        .stall_in(stall),
        .flush_in(flush),
        .pc_out(pc),
        .pc_prev_out(pc_prev),
        .valid_out(valid),
        .misaligned_out(mis),
        .hist_rd_idx_in(rd_idx),
        .hist_data_out(hist_data),
        .hist_count_out(hist_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n;
        logic            stall;
        logic            flush;
        logic [XLEN-1:0] pc_mux;
        logic [IW-1:0]   idx;
        logic [XLEN-1:0] e_pc;
        logic [XLEN-1:0] e_prev;
        logic            e_valid;
        logic            e_mis;
        logic [IW:0]     e_cnt;
        logic [XLEN-1:0] e_hist;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [XLEN-1:0] m,
                        input logic [IW-1:0] i);
        @(negedge clk);
        rst_n  = r;
        stall  = s;
        flush  = f;
        pc_mux = m;
        rd_idx = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, stall, flush, pc_mux, idx | pc, prev, valid, mis, count, hist
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h1234, 2'd0, 32'h0,   32'h0,   1'b0, 1'b0, 3'd0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h1234, 2'd0, 32'h0,   32'h0,   1'b0, 1'b0, 3'd0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h4,    2'd0, 32'h4,   32'h0,   1'b1, 1'b0, 3'd0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h8,    2'd0, 32'h8,   32'h4,   1'b1, 1'b0, 3'd1, 32'h4};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'hC,    2'd1, 32'hC,   32'h8,   1'b1, 1'b0, 3'd2, 32'h4};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h100,  2'd2, 32'hC,   32'h8,   1'b1, 1'b0, 3'd2, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h100,  2'd0, 32'hC,   32'h8,   1'b1, 1'b0, 3'd2, 32'h8};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h100,  2'd0, 32'h100, 32'hC,   1'b1, 1'b0, 3'd3, 32'hC};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h200,  2'd0, 32'h200, 32'hC,   1'b0, 1'b0, 3'd3, 32'hC};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h204,  2'd0, 32'h204, 32'h200, 1'b1, 1'b0, 3'd3, 32'hC};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h102,  2'd0, 32'h102, 32'h204, 1'b1, 1'b1, 3'd4, 32'h204};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h104,  2'd3, 32'h104, 32'h102, 1'b1, 1'b0, 3'd4, 32'h8};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h2,    2'd0, 32'h2,   32'h102, 1'b0, 1'b1, 3'd4, 32'h102};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h8,    2'd0, 32'h8,   32'h2,   1'b1, 1'b0, 3'd4, 32'h102};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_mux = '0; rd_idx = '0;

        for (int v = 0; v < 14; v++) begin
            step(vecs[v].rst_n, vecs[v].stall, vecs[v].flush, vecs[v].pc_mux, vecs[v].idx);
            check($sformatf("v%0d pc", v),    pc,                    vecs[v].e_pc);
            check($sformatf("v%0d prev", v),  pc_prev,               vecs[v].e_prev);
            check($sformatf("v%0d valid", v), XLEN'(valid),          XLEN'(vecs[v].e_valid));
            check($sformatf("v%0d mis", v),   XLEN'(mis),            XLEN'(vecs[v].e_mis));
            check($sformatf("v%0d count", v), XLEN'(hist_count),     XLEN'(vecs[v].e_cnt));
            check($sformatf("v%0d hist", v),  hist_data,             vecs[v].e_hist);
        end

        // Wrap: reset, then advance 0x4..0x1C; six pushes leave 0x18,0x14,0x10,0xC
        step(1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 1'b0, XLEN'(k * 4), 2'd0);
        end
        check("wrap count", XLEN'(hist_count), 32'd4);
        check("wrap idx0", hist_data, 32'h18);
        rd_idx = 2'd3; #1;
        check("wrap idx3", hist_data, 32'hC);
        rd_idx = 2'd1; #1;
        check("wrap idx1", hist_data, 32'h14);

        // Reset while stalled clears everything
        step(1'b1, 1'b1, 1'b0, 32'h500, 2'd0);
        check("stall pc", pc, 32'h1C);
        step(1'b0, 1'b1, 1'b0, 32'h500, 2'd0);
        check("rst count", XLEN'(hist_count), 32'd0);
        check("rst idx0", hist_data, 32'h0);
        check("rst pc", pc, 32'h0);
        check("rst valid", XLEN'(valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
